regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback sources: ALU results and memory-load results.
- Grants one source per cycle using valid/ready handshakes.
- Registers the winning write and drives RegWrite/WriteReg/WriteData into the register write decoder.
- Loads have fixed priority, with a starvation counter that guarantees ALU forward progress.

---
 rtl/regfile_write_arbiter.sv | 89 ++++++++
 tb/tb_regfile_write_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter.
// Two writeback sources (ALU results and memory-load results) share one
// register-file write port. Loads normally win a contested cycle. A saturating
// wait counter tracks how long a pending ALU write has stalled. Once it reaches
// MAX_WAIT, the ALU wins the next contested cycle, so it always makes progress.
// The winning write is registered and presented to the register decoder one
// cycle after the handshake.
module regfile_write_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 2,
  parameter bit DROP_R0  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic        alu_starved
);

  localparam logic [CNT_W-1:0] MaxWaitCnt = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitCntNext;
  logic             forceAlu;
  logic             aluXfer;
  logic             memXfer;

  // Grant: loads win unless the ALU has waited MAX_WAIT cycles. Both readies
  // are held low during reset, so requesters must re-present after reset.
  always_comb begin
    forceAlu  = alu_valid && (waitCnt == MaxWaitCnt);
    mem_ready = !rst && mem_valid && !forceAlu;
    alu_ready = !rst && alu_valid && !mem_ready;
    aluXfer   = alu_valid && alu_ready;
    memXfer   = mem_valid && mem_ready;
  end

  // Wait counter next state: clear when the ALU is idle or granted,
  // otherwise count stalled cycles up to MAX_WAIT and hold there.
  always_comb begin
    waitCntNext = waitCnt;
    if (!alu_valid || aluXfer) begin
      waitCntNext = '0;
    end else if (waitCnt != MaxWaitCnt) begin
      waitCntNext = waitCnt + 1'b1;
    end
  end

  // Wait counter and starvation flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt     <= '0;
      alu_starved <= 1'b0;
    end else begin
      waitCnt     <= waitCntNext;
      alu_starved <= (waitCntNext == MaxWaitCnt);
    end
  end

  // Output stage: capture the granted write. A write to r0 still updates
  // WriteReg/WriteData when DROP_R0 is set, but RegWrite stays low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (memXfer) begin
      RegWrite  <= !(DROP_R0 && (mem_reg == 5'd0));
      WriteReg  <= mem_reg;
      WriteData <= mem_data;
    end else if (aluXfer) begin
      RegWrite  <= !(DROP_R0 && (alu_reg == 5'd0));
      WriteReg  <= alu_reg;
      WriteData <= alu_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter.
// dut uses the default parameters (MAX_WAIT=3, DROP_R0=1).
// dut2 shares the same inputs with MAX_WAIT=0 and DROP_R0=0.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_reg = '0;
  logic [31:0] mem_data = '0;

  logic        alu_ready, mem_ready, RegWrite, alu_starved;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;

  logic        alu_ready2, mem_ready2, RegWrite2, alu_starved2;
  logic [4:0]  WriteReg2;
  logic [31:0] WriteData2;

  int nAsserts = 0;
  int nFail    = 0;
  logic [31:0] rfModel [32];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.MAX_WAIT(3), .CNT_W(2), .DROP_R0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData), .alu_starved(alu_starved)
  );

  regfile_write_arbiter #(.MAX_WAIT(0), .CNT_W(2), .DROP_R0(1'b0)) dut2 (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready2),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready2),
    .RegWrite(RegWrite2), .WriteReg(WriteReg2), .WriteData(WriteData2), .alu_starved(alu_starved2)
  );

  // Register-file model consuming the decoder-side write port.
  always @(negedge clk) begin
    if (RegWrite) rfModel[WriteReg] = WriteData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rfModel[i] = '0;

    // Reset state, with both requests raised to show readies are gated.
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_WriteReg", {27'd0, WriteReg}, 32'd0);
    chk("rst_WriteData", WriteData, 32'd0);
    chk("rst_starved", {31'd0, alu_starved}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single ALU write.
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("t1_mem_ready", {31'd0, mem_ready}, 32'd0);
    step();
    alu_valid = 1'b0;
    chk("t1_RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("t1_WriteReg", {27'd0, WriteReg}, 32'd5);
    chk("t1_WriteData", WriteData, 32'hDEADBEEF);
    step();
    chk("t1_idle_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("t1_hold_WriteReg", {27'd0, WriteReg}, 32'd5);
    chk("t1_hold_WriteData", WriteData, 32'hDEADBEEF);

    // Both valid: load wins first, then ALU. dut2 gives the ALU priority.
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'h11;
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h22;
    #1;
    chk("t2_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("t2_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("t2_p0_alu_ready", {31'd0, alu_ready2}, 32'd1);
    chk("t2_p0_mem_ready", {31'd0, mem_ready2}, 32'd0);
    step();
    mem_valid = 1'b0;
    chk("t2_w1_RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("t2_w1_WriteReg", {27'd0, WriteReg}, 32'd4);
    chk("t2_w1_WriteData", WriteData, 32'h11);
    chk("t2_p0_WriteReg", {27'd0, WriteReg2}, 32'd3);
    #1;
    chk("t2_c1_alu_ready", {31'd0, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    chk("t2_w2_RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("t2_w2_WriteReg", {27'd0, WriteReg}, 32'd3);
    chk("t2_w2_WriteData", WriteData, 32'h22);
    chk("t2_starved", {31'd0, alu_starved}, 32'd0);

    // Starvation: loads every cycle, ALU forced through on the 4th cycle.
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h99;
    mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_reg = 5'(10 + i); mem_data = 32'h100 + 32'(i);
      #1;
      chk($sformatf("t3_stall%0d_mem_ready", i), {31'd0, mem_ready}, 32'd1);
      chk($sformatf("t3_stall%0d_alu_ready", i), {31'd0, alu_ready}, 32'd0);
      step();
      chk($sformatf("t3_stall%0d_WriteReg", i), {27'd0, WriteReg}, 32'(10 + i));
      chk($sformatf("t3_stall%0d_starved", i), {31'd0, alu_starved}, (i == 2) ? 32'd1 : 32'd0);
    end
    mem_reg = 5'd13; mem_data = 32'h103;
    #1;
    chk("t3_force_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("t3_force_mem_ready", {31'd0, mem_ready}, 32'd0);
    step();
    alu_valid = 1'b0;
    chk("t3_alu_WriteReg", {27'd0, WriteReg}, 32'd9);
    chk("t3_alu_WriteData", WriteData, 32'h99);
    chk("t3_starved_clear", {31'd0, alu_starved}, 32'd0);
    #1;
    chk("t3_mem_resume", {31'd0, mem_ready}, 32'd1);
    step();
    mem_valid = 1'b0;
    chk("t3_mem_WriteReg", {27'd0, WriteReg}, 32'd13);
    chk("t3_mem_WriteData", WriteData, 32'h103);

    // Register 0: dropped when DROP_R0=1, written when DROP_R0=0.
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFFFFFF;
    #1;
    chk("t4_alu_ready", {31'd0, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    chk("t4_drop_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("t4_keep_RegWrite", {31'd0, RegWrite2}, 32'd1);
    chk("t4_keep_WriteReg", {27'd0, WriteReg2}, 32'd0);
    chk("t4_keep_WriteData", WriteData2, 32'hFFFFFFFF);
    step();

    // Same destination register: load then ALU; final value is ALU data.
    mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'hA;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hB;
    step();
    mem_valid = 1'b0;
    chk("t5_w1_RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("t5_w1_WriteData", WriteData, 32'hA);
    step();
    alu_valid = 1'b0;
    chk("t5_w2_RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("t5_w2_WriteReg", {27'd0, WriteReg}, 32'd7);
    chk("t5_w2_WriteData", WriteData, 32'hB);
    step();
    chk("t5_r7_final", rfModel[7], 32'hB);

    // Reset mid-operation with a pending write and the ALU starved.
    alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'h2;
    step(); step(); step();
    chk("t6_pre_RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("t6_pre_starved", {31'd0, alu_starved}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("t6_rst_WriteReg", {27'd0, WriteReg}, 32'd0);
    chk("t6_rst_WriteData", WriteData, 32'd0);
    chk("t6_rst_starved", {31'd0, alu_starved}, 32'd0);
    chk("t6_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("t6_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_post_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("t6_post_alu_ready", {31'd0, alu_ready}, 32'd0);
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("t6_post_RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("t6_post_WriteReg", {27'd0, WriteReg}, 32'd2);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
